beep_sequencer: RTL and testbench
=================================

BEEP_SEQUENCER -- requirements
Module: beep_sequencer

Interface
REQ-001 Parameter TONE_HALF, default 24'd50_000, tone half-period in sys_clk cycles (legal range 1..2^24-1).
REQ-002 Parameter BEEP_LEN, default 24'd10_000_000, tone-on duration in sys_clk cycles (legal range 1..2^24-1).
REQ-003 Parameter GAP_LEN, default 24'd5_000_000, silent gap after each beep in sys_clk cycles (legal range 1..2^24-1).
REQ-004 sys_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 beep_req  input  1  single-cycle request pulse, synchronous to sys_clk (debounced key edge).
REQ-007 mute  input  1  level; forces buzzer_out low without altering sequencing.
REQ-008 buzzer_out  output  1  square-wave tone drive.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 pending  output  3  count of queued, not-yet-started beeps.
REQ-011 overflow  output  1  one-cycle pulse when a request is dropped.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BEEP, GAP.
REQ-013 IDLE -> BEEP on an edge where beep_req=1 or pending!=0; that edge clears the duration and tone counters and sets tone phase to 1.
REQ-014 In BEEP, tone phase SHALL toggle on every edge where the tone counter equals TONE_HALF-1; the tone counter then returns to 0, otherwise it increments.
REQ-015 BEEP -> GAP on the edge where the duration counter equals BEEP_LEN-1; tone phase clears to 0 on that edge, giving exactly BEEP_LEN cycles of BEEP.
REQ-016 GAP SHALL last exactly GAP_LEN cycles with tone phase 0, then go to IDLE; GAP never goes directly to BEEP.
REQ-017 Minimum spacing between consecutive beep starts SHALL be BEEP_LEN+GAP_LEN+1 cycles.
REQ-018 buzzer_out SHALL equal registered tone phase AND NOT mute; mute takes effect combinationally.
REQ-019 busy SHALL be decoded from the state register only (1 in BEEP and GAP).
REQ-020 beep_req in BEEP or GAP SHALL increment pending; pending saturates at 7.
REQ-021 beep_req when pending=7 and state is not IDLE SHALL drop the request, leave pending at 7 and pulse overflow for one cycle on the next edge.
REQ-022 IDLE start with pending=0 and beep_req=1: pending stays 0.
REQ-023 IDLE start with pending!=0 and beep_req=0: pending decrements by 1.
REQ-024 IDLE start with pending!=0 and beep_req=1: pending unchanged (one consumed, one queued); no overflow.
REQ-025 beep_req held high for several cycles SHALL count as one request per cycle; no edge detection inside this block.
REQ-026 Counters SHALL be 24-bit and never wrap; terminal compares use ==.

Reset
REQ-027 On sys_rst=1, immediately and independent of sys_clk: state=IDLE, all counters 0, pending=0, tone phase=0, buzzer_out=0, busy=0, overflow=0.
REQ-028 Reset asserted mid-BEEP or mid-GAP SHALL abort the beep and discard all queued requests; beep_req during reset is ignored.
REQ-029 First action after reset release SHALL require a new beep_req.

Verification (TONE_HALF=2, BEEP_LEN=8, GAP_LEN=4)
REQ-030 Single beep_req in IDLE -> from next edge buzzer_out=1,1,0,0,1,1,0,0, then 0; busy high 12 cycles; pending stays 0.
REQ-031 One beep_req during BEEP -> pending=1; after GAP, one IDLE cycle; second identical beep starts; pending returns to 0; starts 13 cycles apart.
REQ-032 Eight beep_req pulses during BEEP -> pending reaches 7; 8th gives one overflow pulse; seven further beeps play, then IDLE.
REQ-033 pending=2 in IDLE plus simultaneous beep_req -> beep starts, pending stays 2, overflow stays 0.
REQ-034 sys_rst pulse mid-BEEP, asynchronous to sys_clk, with pending=3 -> buzzer_out, busy and pending 0 before next edge; FSM in IDLE after release.
REQ-035 mute=1 throughout a beep -> buzzer_out constant 0; busy and pending timing identical to REQ-030.

Source files
------------

// File: rtl/beep_sequencer.sv
// Purpose: queued beep generator; each request plays a square-wave tone burst followed by a silent gap.
// Latency: a tone starts on the edge after a request seen in IDLE; queued beeps restart after one IDLE cycle.
// Backpressure: up to 7 requests queue while busy; further requests are dropped with a one-cycle overflow pulse.
module beep_sequencer #(
  parameter logic [23:0] TONE_HALF = 24'd50_000,
  parameter logic [23:0] BEEP_LEN  = 24'd10_000_000,
  parameter logic [23:0] GAP_LEN   = 24'd5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       beep_req,
  input  logic       mute,
  output logic       buzzer_out,
  output logic       busy,
  output logic [2:0] pending,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] dur_cnt_q, dur_cnt_d;
  logic [23:0] tone_cnt_q, tone_cnt_d;
  logic        tone_q, tone_d;
  logic [2:0]  pending_q, pending_d;
  logic        overflow_q, overflow_d;
  logic        start;

  // A new beep starts from IDLE on a fresh request or a queued one.
  assign start = beep_req || (pending_q != 3'd0);

  // Sequencing: IDLE -> BEEP (tone toggling) -> GAP (silent) -> IDLE.
  always_comb begin
    state_d    = state_q;
    dur_cnt_d  = dur_cnt_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = BEEP;
          dur_cnt_d  = 24'd0;
          tone_cnt_d = 24'd0;
          tone_d     = 1'b1;
        end
      end
      BEEP: begin
        if (tone_cnt_q == TONE_HALF - 24'd1) begin
          tone_d     = ~tone_q;
          tone_cnt_d = 24'd0;
        end else begin
          tone_cnt_d = tone_cnt_q + 24'd1;
        end
        if (dur_cnt_q == BEEP_LEN - 24'd1) begin
          // Tone is forced low for the whole gap regardless of its phase here.
          state_d    = GAP;
          dur_cnt_d  = 24'd0;
          tone_cnt_d = 24'd0;
          tone_d     = 1'b0;
        end else begin
          dur_cnt_d = dur_cnt_q + 24'd1;
        end
      end
      GAP: begin
        tone_d = 1'b0;
        if (dur_cnt_q == GAP_LEN - 24'd1) begin
          // Always pass through IDLE so back-to-back beeps keep a fixed spacing.
          state_d   = IDLE;
          dur_cnt_d = 24'd0;
        end else begin
          dur_cnt_d = dur_cnt_q + 24'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        dur_cnt_d  = 24'd0;
        tone_cnt_d = 24'd0;
        tone_d     = 1'b0;
      end
    endcase
  end

  // Request queue: count requests while busy, consume one per beep start from IDLE.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = 1'b0;
    if (state_q == IDLE) begin
      // A simultaneous request replaces the queued one being consumed.
      if ((pending_q != 3'd0) && !beep_req) begin
        pending_d = pending_q - 3'd1;
      end
    end else if (beep_req) begin
      if (pending_q == 3'd7) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end
  end

  // State and counter registers; reset aborts any beep and flushes the queue.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      dur_cnt_q  <= 24'd0;
      tone_cnt_q <= 24'd0;
      tone_q     <= 1'b0;
      pending_q  <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dur_cnt_q  <= dur_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Mute gates the registered tone combinationally so it acts mid-cycle.
  assign buzzer_out = tone_q & ~mute;
  assign busy       = (state_q != IDLE);
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_beep_sequencer.sv
module tb_beep_sequencer;

  localparam int TH = 2;
  localparam int BL = 8;
  localparam int GL = 4;

  logic       sys_clk;
  logic       sys_rst;
  logic       beep_req;
  logic       mute;
  logic       buzzer_out;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  beep_sequencer #(
    .TONE_HALF(24'(TH)),
    .BEEP_LEN (24'(BL)),
    .GAP_LEN  (24'(GL))
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .beep_req  (beep_req),
    .mute      (mute),
    .buzzer_out(buzzer_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: m_t is the cycle index within the current beep+gap window, -1 when idle.
  int   m_t    = -1;
  int   m_pend = 0;
  logic m_ovf  = 1'b0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_t    = -1;
      m_pend = 0;
      m_ovf  = 1'b0;
    end else begin
      m_ovf = 1'b0;
      if (m_t >= 0) begin
        if (beep_req) begin
          if (m_pend == 7) m_ovf = 1'b1;
          else m_pend++;
        end
        if (m_t == BL + GL - 1) m_t = -1;
        else m_t++;
      end else if (beep_req || m_pend != 0) begin
        if (!beep_req) m_pend--;
        m_t = 0;
      end
    end
  end

  function automatic logic model_tone(input int t);
    return (t >= 0) && (t < BL) && (((t / TH) % 2) == 0);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    logic e_buz, e_busy;
    if (chk_en) begin
      e_buz  = model_tone(m_t) && !mute;
      e_busy = (m_t >= 0);
      n_chk++;
      if (buzzer_out === e_buz && busy === e_busy && pending === 3'(m_pend) && overflow === m_ovf)
        n_pass++;
      else
        $display("FAIL cycle_model t=%0t: buz/busy/pend/ovf got %b/%b/%0d/%b, expected %b/%b/%0d/%b",
                 $time, buzzer_out, busy, pending, overflow, e_buz, e_busy, m_pend, m_ovf);
    end
  end

  // Run log for the literal checks.
  logic buz_log  [128];
  logic busy_log [128];
  int   pend_log [128];
  int   rise_q[$];
  int   ovf_cnt, busy_cnt, max_pend;

  // Cycle i: drive beep_req=req_mask[i] for the edge ending cycle i, sample mid-cycle.
  task automatic run(input int n, input logic [127:0] req_mask);
    logic prev;
    prev = 1'b0;
    rise_q.delete();
    ovf_cnt = 0; busy_cnt = 0; max_pend = 0;
    for (int i = 0; i < n; i++) begin
      beep_req = req_mask[i];
      #2;
      buz_log[i]  = buzzer_out;
      busy_log[i] = busy;
      pend_log[i] = int'(pending);
      if (busy && !prev) rise_q.push_back(i);
      prev = busy;
      if (busy) busy_cnt++;
      if (overflow) ovf_cnt++;
      if (int'(pending) > max_pend) max_pend = int'(pending);
      @(posedge sys_clk);
      #1;
    end
    beep_req = 1'b0;
  endtask

  function automatic int wave9();
    int v;
    v = 0;
    for (int i = 1; i <= 9; i++) v = (v << 1) | int'(buz_log[i]);
    return v;
  endfunction

  function automatic int rise_at(input int k);
    return (rise_q.size() > k) ? rise_q[k] : -1;
  endfunction

  initial begin
    logic [127:0] m;
    sys_rst  = 1'b1;
    beep_req = 1'b0;
    mute     = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_buzzer", int'(buzzer_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overflow", int'(overflow), 0);
    #1 sys_rst = 1'b0;
    chk_en = 1'b1;
    @(posedge sys_clk);
    #1;

    // Single beep from IDLE.
    m = '0; m[0] = 1'b1;
    run(16, m);
    check("single_wave", wave9(), 9'h198);
    check("single_busy_cycles", busy_cnt, 12);
    check("single_start", rise_at(0), 1);
    check("single_pending_max", max_pend, 0);
    check("single_idle_after", int'(busy_log[13]), 0);

    // Same beep under mute: silent, identical timing.
    mute = 1'b1;
    run(16, m);
    check("mute_wave", wave9(), 0);
    check("mute_busy_cycles", busy_cnt, 12);
    check("mute_pending_max", max_pend, 0);
    mute = 1'b0;

    // One queued request during BEEP.
    m = '0; m[0] = 1'b1; m[3] = 1'b1;
    run(30, m);
    check("queue1_pending", pend_log[4], 1);
    check("queue1_idle_gap", int'(busy_log[13]), 0);
    check("queue1_starts", rise_q.size(), 2);
    check("queue1_spacing", rise_at(1) - rise_at(0), 13);
    check("queue1_pending_end", pend_log[14], 0);
    check("queue1_overflow", ovf_cnt, 0);

    // Eight requests during BEEP: saturate at 7 and overflow once.
    m = '0;
    for (int i = 0; i <= 8; i++) m[i] = 1'b1;
    run(110, m);
    check("sat_pending7", pend_log[8], 7);
    check("sat_pending_max", max_pend, 7);
    check("sat_overflow_pulses", ovf_cnt, 1);
    check("sat_beeps", rise_q.size(), 8);
    check("sat_last_start", rise_at(7), 92);
    check("sat_idle_end", int'(busy_log[109]), 0);
    check("sat_pending_end", pend_log[109], 0);

    // Pending=2 in IDLE with a simultaneous request.
    m = '0; m[0] = 1'b1; m[2] = 1'b1; m[3] = 1'b1; m[13] = 1'b1;
    run(60, m);
    check("idle2_pending_before", pend_log[13], 2);
    check("idle2_idle", int'(busy_log[13]), 0);
    check("idle2_pending_after", pend_log[14], 2);
    check("idle2_started", int'(busy_log[14]), 1);
    check("idle2_overflow", ovf_cnt, 0);
    check("idle2_beeps", rise_q.size(), 4);

    // Asynchronous reset mid-BEEP with three queued requests.
    m = '0;
    for (int i = 0; i <= 3; i++) m[i] = 1'b1;
    run(5, m);
    #1;
    check("arst_pre_pending", int'(pending), 3);
    check("arst_pre_buzzer", int'(buzzer_out), 1);
    sys_rst  = 1'b1;
    beep_req = 1'b1;
    #1;
    check("arst_buzzer", int'(buzzer_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_pending", int'(pending), 0);
    #3 beep_req = 1'b0;
    #1 sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    run(8, '0);
    check("post_rst_busy", busy_cnt, 0);
    check("post_rst_pending", max_pend, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
